// File: rtl/framebuffer_swap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_swap_ctrl_pkg
// Description : Shared types and buffer geometry for the framebuffer
//               double-buffer swap controller.
// Revision    : 1.0 - initial release
// ============================================================================
package framebuffer_swap_ctrl_pkg;

    // Buffer geometry for the 160x120 buffer with 12-bit packed colour.
    localparam int BUF_160X120X12_ADDR_WIDTH  = 15;
    localparam int BUF_160X120X12_DEPTH       = 19200;
    localparam int BUF_160X120X12_COLOR_WIDTH = 12;

    // Swap controller state encoding.
    typedef logic [1:0] fb_swap_state_t;

    localparam fb_swap_state_t c_st_idle        = 2'd0;
    localparam fb_swap_state_t c_st_wait_vblank = 2'd1;
    localparam fb_swap_state_t c_st_swap        = 2'd2;
    localparam fb_swap_state_t c_st_clear       = 2'd3;

endpackage
`default_nettype wire

// File: rtl/framebuffer_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_swap_ctrl
// Description : Double-buffer controller. Selects the scanned (front) bank,
//               commits renderer swap requests only during vertical blank and
//               routes every write to the back bank through one register
//               stage. Optional macro FB_AUTO_CLEAR_EN adds a CLEAR state
//               that sweeps the new back bank with clear_color after each
//               swap and after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_swap_ctrl
    import framebuffer_swap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUF_160X120X12_ADDR_WIDTH,
    parameter int DEPTH       = BUF_160X120X12_DEPTH,
    parameter int COLOR_WIDTH = BUF_160X120X12_COLOR_WIDTH
) (
    input  logic                   clk_pixel,
    input  logic                   rst_pixel,
    input  logic                   vblank,
    input  logic                   swap_req,
    output logic                   swap_ack,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    input  logic                   render_we,
    input  logic [ADDR_WIDTH-1:0]  render_addr,
    input  logic [COLOR_WIDTH-1:0] render_data,
    output logic                   render_ready,
    output logic                   front_sel,
    output logic                   wr_en,
    output logic                   wr_bank,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [COLOR_WIDTH-1:0] wr_data,
    output logic                   busy
);

    localparam logic [ADDR_WIDTH-1:0] c_clr_last = ADDR_WIDTH'(DEPTH - 1);

`ifdef FB_AUTO_CLEAR_EN
    // After reset the initial back bank (bank 1) is swept before rendering.
    localparam fb_swap_state_t c_st_reset = c_st_clear;
`else
    localparam fb_swap_state_t c_st_reset = c_st_idle;
`endif

    fb_swap_state_t          r_state;
    fb_swap_state_t          w_state_nxt;
    logic                    r_front_sel;
    logic                    r_swap_ack;
    logic                    r_wr_en;
    logic                    r_wr_bank;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [COLOR_WIDTH-1:0]  r_wr_data;
    logic                    w_render_ready;
    logic                    w_clr_step;
    logic                    w_clr_done;
    logic [ADDR_WIDTH-1:0]   w_clr_addr;

`ifdef FB_AUTO_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;

    assign w_clr_step = (r_state == c_st_clear);
    assign w_clr_done = (r_clr_cnt == c_clr_last);
    assign w_clr_addr = r_clr_cnt;

    // Clear counter: steps once per CLEAR cycle, returns to 0 after the last word.
    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_clr_cnt <= '0;
        end else if (w_clr_step) begin
            r_clr_cnt <= w_clr_done ? '0 : r_clr_cnt + 1'b1;
        end
    end
`else
    assign w_clr_step = 1'b0;
    assign w_clr_done = 1'b1;
    assign w_clr_addr = '0;

    // clear_color and the depth are meaningless without the clear sweep.
    logic w_unused_clear;
    assign w_unused_clear = ^{clear_color, c_clr_last};
`endif

    // Renderer may write while no swap is being committed or cleared.
    assign w_render_ready = (r_state == c_st_idle) || (r_state == c_st_wait_vblank);

    // Next-state logic; swap_req only matters in IDLE, vblank is a level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:        if (swap_req) w_state_nxt = c_st_wait_vblank;
            c_st_wait_vblank: if (vblank)   w_state_nxt = c_st_swap;
`ifdef FB_AUTO_CLEAR_EN
            c_st_swap:        w_state_nxt = c_st_clear;
`else
            c_st_swap:        w_state_nxt = c_st_idle;
`endif
            c_st_clear:       if (w_clr_done) w_state_nxt = c_st_idle;
            default:          w_state_nxt = c_st_idle;
        endcase
    end

    // State, front bank and swap acknowledge; front flips on entry to SWAP.
    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_state     <= c_st_reset;
            r_front_sel <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_swap_ack <= (w_state_nxt == c_st_swap);
            if (w_state_nxt == c_st_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // Registered write path; bank is the back bank as seen at issue time.
    always_ff @(posedge clk_pixel) begin
        if (rst_pixel) begin
            r_wr_en   <= 1'b0;
            r_wr_bank <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_clr_step) begin
            r_wr_en   <= 1'b1;
            r_wr_bank <= ~r_front_sel;
            r_wr_addr <= w_clr_addr;
            r_wr_data <= clear_color;
        end else if (render_we && w_render_ready) begin
            r_wr_en   <= 1'b1;
            r_wr_bank <= ~r_front_sel;
            r_wr_addr <= render_addr;
            r_wr_data <= render_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign swap_ack     = r_swap_ack;
    assign render_ready = w_render_ready;
    assign front_sel    = r_front_sel;
    assign wr_en        = r_wr_en;
    assign wr_bank      = r_wr_bank;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_swap_ctrl
// Description : Directed self-checking bench for framebuffer_swap_ctrl.
//               Builds with or without FB_AUTO_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_swap_ctrl;
    import framebuffer_swap_ctrl_pkg::*;

    localparam int AW    = BUF_160X120X12_ADDR_WIDTH;
    localparam int DEPTH = BUF_160X120X12_DEPTH;
    localparam int CW    = BUF_160X120X12_COLOR_WIDTH;
`ifdef FB_AUTO_CLEAR_EN
    localparam bit c_clr = 1'b1;
`else
    localparam bit c_clr = 1'b0;
`endif
    localparam logic [CW-1:0] c_clear_color = 12'hABC;

    logic          clk_pixel = 1'b0;
    logic          rst_pixel;
    logic          vblank;
    logic          swap_req;
    logic          swap_ack;
    logic [CW-1:0] clear_color;
    logic          render_we;
    logic [AW-1:0] render_addr;
    logic [CW-1:0] render_data;
    logic          render_ready;
    logic          front_sel;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          busy;

    int   total = 0;
    int   bad   = 0;
    logic exp_front;

    framebuffer_swap_ctrl dut (
        .clk_pixel    (clk_pixel),
        .rst_pixel    (rst_pixel),
        .vblank       (vblank),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .clear_color  (clear_color),
        .render_we    (render_we),
        .render_addr  (render_addr),
        .render_data  (render_data),
        .render_ready (render_ready),
        .front_sel    (front_sel),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Advance one clock; drive and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Bounded wait for the controller to return to IDLE.
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < DEPTH + 20) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        int nbadw = 0;
        rst_pixel   = 1'b1;
        vblank      = 1'b0;
        swap_req    = 1'b0;
        render_we   = 1'b0;
        render_addr = '0;
        render_data = '0;
        clear_color = c_clear_color;
        tick();
        tick();
        total++;
        if ({front_sel, swap_ack, wr_en, wr_bank} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_ctrl: front/ack/wr_en/wr_bank=%b want 0001",
                     {front_sel, swap_ack, wr_en, wr_bank});
        end
        total++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            bad++;
            $display("FAIL reset_wr: addr=%0d data=%h want 0/000", wr_addr, wr_data);
        end
        total++;
        if (busy !== c_clr || render_ready !== !c_clr) begin
            bad++;
            $display("FAIL reset_state: busy=%b ready=%b want %b/%b",
                     busy, render_ready, c_clr, !c_clr);
        end
        rst_pixel = 1'b0;
        exp_front = 1'b0;
`ifdef FB_AUTO_CLEAR_EN
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            if (!(wr_en === 1'b1 && wr_bank === 1'b1 && wr_addr === AW'(k - 1) &&
                  wr_data === c_clear_color)) begin
                nbadw++;
            end
        end
        total++;
        if (nbadw != 0) begin
            bad++;
            $display("FAIL reset_sweep: %0d bad clear writes, want 0", nbadw);
        end
        total++;
        if (busy !== 1'b0 || render_ready !== 1'b1 || front_sel !== 1'b0) begin
            bad++;
            $display("FAIL sweep_end: busy=%b ready=%b front=%b want 0/1/0",
                     busy, render_ready, front_sel);
        end
`endif
        tick();
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: wr_en=%b busy=%b want 0/0", wr_en, busy);
        end
    endtask

    task automatic test_wait_vblank();
        swap_req = 1'b1;
        vblank   = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (swap_ack !== 1'b0 || busy !== 1'b1 || render_ready !== 1'b1 ||
                front_sel !== exp_front) begin
                bad++;
                $display("FAIL wait_hold[%0d]: ack=%b busy=%b ready=%b front=%b want 0/1/1/%b",
                         i, swap_ack, busy, render_ready, front_sel, exp_front);
            end
            tick();
        end
        vblank = 1'b1;
        tick();
        exp_front = ~exp_front;
        total++;
        if (swap_ack !== 1'b1 || front_sel !== exp_front || render_ready !== 1'b0) begin
            bad++;
            $display("FAIL wait_swap: ack=%b front=%b ready=%b want 1/%b/0",
                     swap_ack, front_sel, render_ready, exp_front);
        end
        swap_req = 1'b0;
        vblank   = 1'b0;
        tick();
        total++;
        if (swap_ack !== 1'b0) begin
            bad++;
            $display("FAIL wait_ack_pulse: ack=%b want 0", swap_ack);
        end
        if (c_clr) wait_idle();
    endtask

    task automatic test_vblank_high();
        vblank   = 1'b1;
        swap_req = 1'b1;
        tick();
        total++;
        if (swap_ack !== 1'b0 || render_ready !== 1'b1) begin
            bad++;
            $display("FAIL vbh_first: ack=%b ready=%b want 0/1", swap_ack, render_ready);
        end
        tick();
        exp_front = ~exp_front;
        total++;
        if (swap_ack !== 1'b1 || front_sel !== exp_front) begin
            bad++;
            $display("FAIL vbh_ack: ack=%b front=%b want 1/%b", swap_ack, front_sel, exp_front);
        end
        swap_req = 1'b0;
        vblank   = 1'b0;
        tick();
        total++;
        if (swap_ack !== 1'b0) begin
            bad++;
            $display("FAIL vbh_pulse: ack=%b want 0", swap_ack);
        end
        if (c_clr) wait_idle();
    endtask

    task automatic test_write_before_swap();
        logic old_back;
        swap_req = 1'b1;
        vblank   = 1'b0;
        tick();
        old_back    = ~exp_front;
        vblank      = 1'b1;
        render_we   = 1'b1;
        render_addr = 15'd5;
        render_data = 12'h0F0;
        tick();
        exp_front = ~exp_front;
        total++;
        if (wr_en !== 1'b1 || wr_bank !== old_back || wr_addr !== 15'd5 ||
            wr_data !== 12'h0F0) begin
            bad++;
            $display("FAIL pre_swap_write: en=%b bank=%b addr=%0d data=%h want 1/%b/5/0f0",
                     wr_en, wr_bank, wr_addr, wr_data, old_back);
        end
        swap_req    = 1'b0;
        vblank      = 1'b0;
        render_addr = 15'd7;
        render_data = 12'h123;
        tick();
        total++;
        if (wr_en !== 1'b0) begin
            bad++;
            $display("FAIL swap_drop: wr_en=%b want 0", wr_en);
        end
`ifdef FB_AUTO_CLEAR_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (wr_en !== 1'b1 || wr_bank !== ~exp_front || wr_addr !== AW'(i) ||
                wr_data !== c_clear_color) begin
                bad++;
                $display("FAIL clear_drop[%0d]: en=%b bank=%b addr=%0d data=%h want 1/%b/%0d/abc",
                         i, wr_en, wr_bank, wr_addr, wr_data, ~exp_front, i);
            end
        end
`endif
        render_we = 1'b0;
    endtask

`ifdef FB_AUTO_CLEAR_EN
    // Continues from the clear started by test_write_before_swap (addr 2 issued).
    task automatic test_reset_mid_clear();
        repeat (97) tick();
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 15'd99) begin
            bad++;
            $display("FAIL mid_clear: en=%b addr=%0d want 1/99", wr_en, wr_addr);
        end
        rst_pixel = 1'b1;
        tick();
        exp_front = 1'b0;
        total++;
        if (wr_en !== 1'b0 || front_sel !== 1'b0 || swap_ack !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: en=%b front=%b ack=%b busy=%b want 0/0/0/1",
                     wr_en, front_sel, swap_ack, busy);
        end
        rst_pixel = 1'b0;
        tick();
        total++;
        if (wr_en !== 1'b1 || wr_addr !== '0 || wr_bank !== 1'b1) begin
            bad++;
            $display("FAIL clear_restart: en=%b addr=%0d bank=%b want 1/0/1",
                     wr_en, wr_addr, wr_bank);
        end
        wait_idle();
    endtask
`else
    task automatic test_back_to_back();
        rst_pixel = 1'b1;
        tick();
        rst_pixel = 1'b0;
        exp_front = 1'b0;
        for (int s = 0; s < 2; s++) begin
            swap_req = 1'b1;
            vblank   = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                total++;
                if (render_ready !== 1'b1 || swap_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_wait[%0d.%0d]: ready=%b ack=%b want 1/0",
                             s, i, render_ready, swap_ack);
                end
            end
            vblank = 1'b1;
            tick();
            exp_front = ~exp_front;
            total++;
            if (render_ready !== 1'b0 || swap_ack !== 1'b1 || front_sel !== exp_front) begin
                bad++;
                $display("FAIL b2b_swap[%0d]: ready=%b ack=%b front=%b want 0/1/%b",
                         s, render_ready, swap_ack, front_sel, exp_front);
            end
            swap_req = 1'b0;
            vblank   = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                total++;
                if (render_ready !== 1'b1 || swap_ack !== 1'b0 || front_sel !== exp_front) begin
                    bad++;
                    $display("FAIL b2b_after[%0d.%0d]: ready=%b ack=%b front=%b want 1/0/%b",
                             s, i, render_ready, swap_ack, front_sel, exp_front);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wait_vblank();
        test_vblank_high();
        test_write_before_swap();
`ifdef FB_AUTO_CLEAR_EN
        test_reset_mid_clear();
`else
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
